// File: rtl/openram_testchip_ctrl.sv
`default_nettype none
// =============================================================================
// openram_testchip_ctrl: packet-driven access controller for five OpenRAM macros
// Revision: 1.0
// =============================================================================
module openram_testchip_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         la_in_load,
  input  logic         gpio_in_scan,
  input  logic         la_sram_load,
  input  logic         gpio_sram_load,
  input  logic         gpio_out_scan,
  input  logic [111:0] la_bits,
  input  logic         gpio_bit,
  input  logic         in_select,
  input  logic [31:0]  sram0_rw_in,
  input  logic [31:0]  sram0_ro_in,
  input  logic [31:0]  sram1_rw_in,
  input  logic [31:0]  sram1_ro_in,
  input  logic [31:0]  sram2_rw_in,
  input  logic [31:0]  sram3_rw_in,
  input  logic [31:0]  sram4_rw_in,
  output logic [54:0]  sram0_connections,
  output logic [54:0]  sram1_connections,
  output logic [47:0]  sram2_connections,
  output logic [45:0]  sram3_connections,
  output logic [46:0]  sram4_connections,
  output logic [31:0]  la_data0,
  output logic [31:0]  la_data1,
  output logic         gpio_data0,
  output logic         gpio_data1
);
  localparam int NUM_SRAM = 5;

  logic [111:0] pkt_q, pkt_d;
  logic [31:0]  data0_q, data0_d, data1_q, data1_d;
  logic         ld_q, ld_d, rd0_q, rd0_d, rd1_q, rd1_d;
  logic [3:0]   sel_q, sel_d;

  logic [3:0]   sel;
  logic [15:0]  addr0, addr1;
  logic [31:0]  din0;
  logic         csb0, web0, csb1;
  logic [3:0]   wmask0;
  logic         sram_load;
  logic [NUM_SRAM-1:0] csb0_gate, csb1_gate;
  logic [31:0]  rw_mux, ro_mux;
  logic         cap0, cap1;
  logic         unused_pkt_bits;

  assign sel    = pkt_q[111:108];
  assign addr0  = pkt_q[107:92];
  assign din0   = pkt_q[91:60];
  assign csb0   = pkt_q[59];
  assign web0   = pkt_q[58];
  assign wmask0 = pkt_q[57:54];
  assign addr1  = pkt_q[53:38];
  assign csb1   = pkt_q[5];
  // Port-1 write fields exist in the packet format but no macro uses them.
  assign unused_pkt_bits = ^{addr0[15:10], addr1[15:8], pkt_q[37:6], pkt_q[4:0]};

  assign sram_load = in_select ? gpio_sram_load : la_sram_load;

  for (genvar k = 0; k < NUM_SRAM; k++) begin : g_csb
    assign csb0_gate[k] = (sram_load && (sel == 4'(k))) ? csb0 : 1'b1;
    assign csb1_gate[k] = (sram_load && (sel == 4'(k))) ? csb1 : 1'b1;
  end

  assign sram0_connections = {csb0_gate[0], web0, wmask0, addr0[7:0], din0, csb1_gate[0], addr1[7:0]};
  assign sram1_connections = {csb0_gate[1], web0, wmask0, addr0[7:0], din0, csb1_gate[1], addr1[7:0]};
  assign sram2_connections = {csb0_gate[2], web0, wmask0, addr0[9:0], din0};
  assign sram3_connections = {csb0_gate[3], web0, wmask0, addr0[7:0], din0};
  assign sram4_connections = {csb0_gate[4], web0, wmask0, addr0[8:0], din0};

  always_comb begin
    rw_mux = '0;
    ro_mux = '0;
    case (sel_q)
      4'd0: begin rw_mux = sram0_rw_in; ro_mux = sram0_ro_in; end
      4'd1: begin rw_mux = sram1_rw_in; ro_mux = sram1_ro_in; end
      4'd2: rw_mux = sram2_rw_in;
      4'd3: rw_mux = sram3_rw_in;
      4'd4: rw_mux = sram4_rw_in;
      default: ;
    endcase
  end

  always_comb begin
    pkt_d = pkt_q;
    if (!in_select && la_in_load) begin
      pkt_d = la_bits;
    end else if (in_select && gpio_in_scan) begin
      pkt_d = {pkt_q[110:0], gpio_bit};
    end

    ld_d  = sram_load;
    sel_d = sel;
    rd0_d = !csb0 && web0;
    rd1_d = !csb1;

    // Issue state from the previous cycle picks up the macro's dout now.
    cap0    = ld_q && rd0_q;
    cap1    = ld_q && rd1_q;
    data0_d = data0_q;
    data1_d = data1_q;
    if (cap0 || cap1) begin
      if (cap0) data0_d = rw_mux;
      if (cap1) data1_d = ro_mux;
    end else if (gpio_out_scan) begin
      data0_d = {data0_q[30:0], 1'b0};
      data1_d = {data1_q[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pkt_q   <= '0;
      data0_q <= '0;
      data1_q <= '0;
      ld_q    <= 1'b0;
      sel_q   <= '0;
      rd0_q   <= 1'b0;
      rd1_q   <= 1'b0;
    end else begin
      pkt_q   <= pkt_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      ld_q    <= ld_d;
      sel_q   <= sel_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  assign la_data0   = data0_q;
  assign la_data1   = data1_q;
  assign gpio_data0 = data0_q[31];
  assign gpio_data1 = data1_q[31];
endmodule
`default_nettype wire

// File: tb/tb_openram_testchip_ctrl.sv
`default_nettype none
// =============================================================================
// tb_openram_testchip_ctrl: vectors, corner sequences and random traffic
// against behavioural SRAM macros and a transaction-level reference model.
// =============================================================================
module tb_openram_testchip_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, la_in_load, gpio_in_scan, la_sram_load, gpio_sram_load, gpio_out_scan;
  logic gpio_bit, in_select;
  logic [111:0] la_bits;
  logic [31:0] sram0_rw_in = '0, sram0_ro_in = '0, sram1_rw_in = '0, sram1_ro_in = '0;
  logic [31:0] sram2_rw_in = '0, sram3_rw_in = '0, sram4_rw_in = '0;
  logic [54:0] s0c, s1c;
  logic [47:0] s2c;
  logic [45:0] s3c;
  logic [46:0] s4c;
  logic [31:0] la_data0, la_data1;
  logic gpio_data0, gpio_data1;

  openram_testchip_ctrl dut (
    .clk(clk), .reset(reset), .la_in_load(la_in_load), .gpio_in_scan(gpio_in_scan),
    .la_sram_load(la_sram_load), .gpio_sram_load(gpio_sram_load), .gpio_out_scan(gpio_out_scan),
    .la_bits(la_bits), .gpio_bit(gpio_bit), .in_select(in_select),
    .sram0_rw_in(sram0_rw_in), .sram0_ro_in(sram0_ro_in),
    .sram1_rw_in(sram1_rw_in), .sram1_ro_in(sram1_ro_in),
    .sram2_rw_in(sram2_rw_in), .sram3_rw_in(sram3_rw_in), .sram4_rw_in(sram4_rw_in),
    .sram0_connections(s0c), .sram1_connections(s1c), .sram2_connections(s2c),
    .sram3_connections(s3c), .sram4_connections(s4c),
    .la_data0(la_data0), .la_data1(la_data1), .gpio_data0(gpio_data0), .gpio_data1(gpio_data1)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction

  // Behavioural macros: sample on the rising edge, dout valid the next cycle.
  logic [31:0] m0 [256] = '{default: '0};
  logic [31:0] m1 [256] = '{default: '0};
  logic [31:0] m2 [1024] = '{default: '0};
  logic [31:0] m3 [256] = '{default: '0};
  logic [31:0] m4 [512] = '{default: '0};

  always @(posedge clk) begin
    if (!s0c[54]) begin
      if (!s0c[53]) m0[s0c[48:41]] <= merge(m0[s0c[48:41]], s0c[40:9], s0c[52:49]);
      else sram0_rw_in <= m0[s0c[48:41]];
    end
    if (!s0c[8]) sram0_ro_in <= m0[s0c[7:0]];
    if (!s1c[54]) begin
      if (!s1c[53]) m1[s1c[48:41]] <= merge(m1[s1c[48:41]], s1c[40:9], s1c[52:49]);
      else sram1_rw_in <= m1[s1c[48:41]];
    end
    if (!s1c[8]) sram1_ro_in <= m1[s1c[7:0]];
    if (!s2c[47]) begin
      if (!s2c[46]) m2[s2c[41:32]] <= merge(m2[s2c[41:32]], s2c[31:0], s2c[45:42]);
      else sram2_rw_in <= m2[s2c[41:32]];
    end
    if (!s3c[45]) begin
      if (!s3c[44]) m3[s3c[39:32]] <= merge(m3[s3c[39:32]], s3c[31:0], s3c[43:40]);
      else sram3_rw_in <= m3[s3c[39:32]];
    end
    if (!s4c[46]) begin
      if (!s4c[45]) m4[s4c[40:32]] <= merge(m4[s4c[40:32]], s4c[31:0], s4c[44:41]);
      else sram4_rw_in <= m4[s4c[40:32]];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level reference: per-macro memory contents plus the two data words.
  logic [31:0] rmem [5][1024] = '{default: '{default: '0}};
  logic [31:0] r_d0 = '0, r_d1 = '0;

  function automatic int depth(input int s);
    case (s)
      2: return 1024;
      4: return 512;
      default: return 256;
    endcase
  endfunction

  task automatic model_issue(input logic [111:0] p);
    int s, a0, a1;
    logic [31:0] nd0, nd1;
    s   = int'(p[111:108]);
    a0  = int'(p[107:92]) % depth(s);
    a1  = int'(p[45:38]);
    nd0 = r_d0;
    nd1 = r_d1;
    if (!p[5]) nd1 = (s < 2) ? rmem[s][a1] : 32'd0;
    if (!p[59] && p[58]) nd0 = (s < 5) ? rmem[s][a0] : 32'd0;
    if (!p[59] && !p[58] && s < 5) rmem[s][a0] = merge(rmem[s][a0], p[91:60], p[57:54]);
    r_d0 = nd0;
    r_d1 = nd1;
  endtask

  function automatic logic [6:0] exp_csb(input logic [111:0] p, input logic ld);
    logic [6:0] r;
    r = 7'h7F;
    if (ld) begin
      case (int'(p[111:108]))
        0: begin r[6] = p[59]; r[5] = p[5]; end
        1: begin r[4] = p[59]; r[3] = p[5]; end
        2: r[2] = p[59];
        3: r[1] = p[59];
        4: r[0] = p[59];
        default: ;
      endcase
    end
    return r;
  endfunction

  function automatic logic [6:0] act_csb();
    return {s0c[54], s0c[8], s1c[54], s1c[8], s2c[47], s3c[45], s4c[46]};
  endfunction

  function automatic logic [111:0] mkp(input logic [3:0] s, input logic [15:0] a0, input logic [31:0] d0,
                                       input logic c0, input logic w0, input logic [3:0] wm,
                                       input logic [15:0] a1, input logic c1);
    return {s, a0, d0, c0, w0, wm, a1, 32'd0, c1, 1'b1, 4'd0};
  endfunction

  task automatic load_pkt(input logic [111:0] p, input logic gp);
    if (!gp) begin
      in_select = 1'b0; la_bits = p; la_in_load = 1'b1;
      @(negedge clk);
      la_in_load = 1'b0;
    end else begin
      // LA load held active with an inverted packet: must be ignored in GPIO mode.
      in_select = 1'b1; la_bits = ~p; la_in_load = 1'b1;
      for (int i = 111; i >= 0; i--) begin
        gpio_bit = p[i]; gpio_in_scan = 1'b1;
        @(negedge clk);
      end
      gpio_in_scan = 1'b0; la_in_load = 1'b0;
    end
  endtask

  task automatic issue(input logic [111:0] p, input logic gp, input string nm);
    load_pkt(p, gp);
    if (gp) gpio_sram_load = 1'b1;
    else begin
      la_sram_load = 1'b1;
      gpio_sram_load = 1'($urandom_range(0, 1));
    end
    #1 chk({nm, " csb"}, 64'(act_csb()), 64'(exp_csb(p, 1'b1)));
    @(negedge clk);
    la_sram_load = 1'b0; gpio_sram_load = 1'b0;
    model_issue(p);
    @(negedge clk);
  endtask

  task automatic scan(input int k);
    gpio_out_scan = 1'b1;
    repeat (k) @(negedge clk);
    gpio_out_scan = 1'b0;
    r_d0 = r_d0 << k;
    r_d1 = r_d1 << k;
  endtask

  typedef struct {
    logic [111:0] pkt;
    logic [31:0]  exp0;
    logic [31:0]  exp1;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [11];
    logic [31:0] got0, got1;
    logic [111:0] p, pa, pb;

    vt[0]  = '{mkp(4'd0, 16'd1, 32'h1, 1'b0, 1'b0, 4'hF, 16'd0, 1'b1), 32'h0, 32'h0};
    vt[1]  = '{mkp(4'd0, 16'd1, 32'h0, 1'b0, 1'b1, 4'h0, 16'd0, 1'b1), 32'h1, 32'h0};
    vt[2]  = '{mkp(4'd1, 16'd5, 32'hDEADBEEF, 1'b0, 1'b0, 4'hF, 16'd0, 1'b1), 32'h1, 32'h0};
    vt[3]  = '{mkp(4'd1, 16'd0, 32'h0, 1'b1, 1'b1, 4'h0, 16'd5, 1'b0), 32'h1, 32'hDEADBEEF};
    vt[4]  = '{mkp(4'd3, 16'h0020, 32'h12345678, 1'b0, 1'b0, 4'hF, 16'd0, 1'b1), 32'h1, 32'hDEADBEEF};
    vt[5]  = '{mkp(4'd3, 16'h0020, 32'h0, 1'b0, 1'b1, 4'h0, 16'd0, 1'b0), 32'h12345678, 32'h0};
    vt[6]  = '{mkp(4'd4, 16'h01FF, 32'hCAFEF00D, 1'b0, 1'b0, 4'b1100, 16'd0, 1'b1), 32'h12345678, 32'h0};
    vt[7]  = '{mkp(4'd4, 16'hFFFF, 32'h0, 1'b0, 1'b1, 4'h0, 16'd0, 1'b1), 32'hCAFE0000, 32'h0};
    vt[8]  = '{mkp(4'd7, 16'd1, 32'h0, 1'b0, 1'b1, 4'h0, 16'd5, 1'b0), 32'h0, 32'h0};
    vt[9]  = '{mkp(4'd1, 16'h0105, 32'h0, 1'b0, 1'b1, 4'h0, 16'hAB05, 1'b0), 32'hDEADBEEF, 32'hDEADBEEF};
    vt[10] = '{mkp(4'd3, 16'h0120, 32'h0, 1'b0, 1'b1, 4'h0, 16'd0, 1'b1), 32'h12345678, 32'hDEADBEEF};

    reset = 1'b0; la_in_load = 1'b0; gpio_in_scan = 1'b0; la_sram_load = 1'b0;
    gpio_sram_load = 1'b0; gpio_out_scan = 1'b0; gpio_bit = 1'b0; in_select = 1'b0; la_bits = '0;

    // Reset
    repeat (2) @(negedge clk);
    chk("reset csb during", 64'(act_csb()), 64'h7F);
    reset = 1'b1;
    @(negedge clk);
    chk("reset csb after", 64'(act_csb()), 64'h7F);
    chk("reset la_data0", 64'(la_data0), 64'h0);
    chk("reset la_data1", 64'(la_data1), 64'h0);
    chk("reset gpio_data", 64'({gpio_data0, gpio_data1}), 64'h0);

    // LA-mode vectors
    for (int i = 0; i < 11; i++) begin
      issue(vt[i].pkt, 1'b0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d la_data0", i), 64'(la_data0), 64'(vt[i].exp0));
      chk($sformatf("vec%0d la_data1", i), 64'(la_data1), 64'(vt[i].exp1));
      chk($sformatf("vec%0d gpio_data", i), 64'({gpio_data0, gpio_data1}),
          64'({vt[i].exp0[31], vt[i].exp1[31]}));
    end

    // Non-selected source's issue strobe is ignored
    in_select = 1'b1; la_sram_load = 1'b1; la_in_load = 1'b1; la_bits = vt[1].pkt;
    #1 chk("gate csb", 64'(act_csb()), 64'h7F);
    @(negedge clk);
    la_sram_load = 1'b0; la_in_load = 1'b0;
    repeat (2) @(negedge clk);
    chk("gate la_data0", 64'(la_data0), 64'h12345678);

    // GPIO path with partial byte mask, then serial readout
    issue(mkp(4'd2, 16'd1000, 32'hA5A5A5A5, 1'b0, 1'b0, 4'b0011, 16'd0, 1'b1), 1'b1, "gpio wr");
    issue(mkp(4'd2, 16'd1000, 32'h0, 1'b0, 1'b1, 4'h0, 16'd0, 1'b1), 1'b1, "gpio rd");
    chk("gpio rd la_data0", 64'(la_data0), 64'h0000A5A5);
    got0 = '0; got1 = '0;
    gpio_out_scan = 1'b1;
    for (int i = 0; i < 32; i++) begin
      got0 = {got0[30:0], gpio_data0};
      got1 = {got1[30:0], gpio_data1};
      @(negedge clk);
    end
    gpio_out_scan = 1'b0;
    r_d0 = '0; r_d1 = '0;
    chk("scan stream0", 64'(got0), 64'h0000A5A5);
    chk("scan stream1", 64'(got1), 64'hDEADBEEF);
    chk("scan drained", 64'({la_data0, la_data1}), 64'h0);

    // Reset in the cycle after a read issue aborts the capture
    issue(mkp(4'd0, 16'd1, 32'h0, 1'b0, 1'b1, 4'h0, 16'd1, 1'b0), 1'b0, "pre-abort");
    chk("pre-abort la_data0", 64'(la_data0), 64'h1);
    load_pkt(mkp(4'd1, 16'd5, 32'h0, 1'b0, 1'b1, 4'h0, 16'd5, 1'b0), 1'b0);
    la_sram_load = 1'b1;
    @(negedge clk);
    la_sram_load = 1'b0; reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    r_d0 = '0; r_d1 = '0;
    chk("abort data", 64'({la_data0, la_data1}), 64'h0);
    @(negedge clk);
    chk("abort data later", 64'({la_data0, la_data1}), 64'h0);
    chk("abort csb", 64'(act_csb()), 64'h7F);

    // Back-to-back issues; second capture coincides with a scan request
    pa = mkp(4'd2, 16'd1000, 32'h0, 1'b0, 1'b1, 4'h0, 16'd0, 1'b1);
    pb = mkp(4'd1, 16'd5, 32'h0, 1'b0, 1'b1, 4'h0, 16'd5, 1'b0);
    in_select = 1'b0; la_bits = pa; la_in_load = 1'b1;
    @(negedge clk);
    la_bits = pb; la_sram_load = 1'b1;
    @(negedge clk);
    la_in_load = 1'b0;
    model_issue(pa);
    @(negedge clk);
    la_sram_load = 1'b0; gpio_out_scan = 1'b1;
    chk("b2b first la_data0", 64'(la_data0), 64'(r_d0));
    model_issue(pb);
    @(negedge clk);
    gpio_out_scan = 1'b0;
    chk("b2b second la_data0", 64'(la_data0), 64'(r_d0));
    chk("b2b second la_data1", 64'(la_data1), 64'(r_d1));

    // Random traffic against the reference model
    for (int t = 0; t < 120; t++) begin
      logic [3:0] s;
      s = ($urandom_range(0, 7) < 6) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(5, 15));
      p = mkp(s, 16'($urandom_range(0, 7)) | (16'($urandom) & 16'hFC00), 32'($urandom),
              ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), 4'($urandom),
              16'($urandom_range(0, 7)) | (16'($urandom) & 16'hFF00), 1'($urandom_range(0, 1)));
      p[37:6] = 32'($urandom);
      p[4:0]  = 5'($urandom);
      issue(p, ($urandom_range(0, 9) == 0), $sformatf("rnd%0d", t));
      chk($sformatf("rnd%0d data", t), {la_data0, la_data1}, {r_d0, r_d1});
      if ($urandom_range(0, 3) == 0) begin
        scan($urandom_range(1, 6));
        chk($sformatf("rnd%0d scan", t), {la_data0, la_data1}, {r_d0, r_d1});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
